scg_param: RTL and testbench
============================

Name: scg_param

Overview:
- Parametrised successor to the SDRAM subroutine command generator. Accepts one controller opcode at a time and emits the full SDRAM command sequence for it.
- A single FSM plus one shared interval timer replace the per-command sub-FSMs and the hard-wired init counter.
- All SDRAM timings, the burst length and the init wait are parameters.
- Adds explicit self-refresh hold/exit, a done pulse, and a data-phase strobe for multi-beat bursts.
- Sits between the controller's top FSM (opcode/mode source) and the SDRAM pin driver (command decode).

Parameters:
- INIT_CYCLES, 14286, NOP cycles after reset before PALL in the init sequence
- INIT_REFRESHES, 2, AREF commands issued during init
- T_RP, 2, cycles from PALL or last precharge-affecting beat to next command
- T_RCD, 2, cycles from ACT to READ/WRITE
- T_RFC, 7, cycles from AREF to next command
- T_MRD, 2, cycles from MRS to done
- T_WR, 2, write recovery cycles after last write beat
- T_XSR, 8, NOP cycles after self-refresh exit before done
- CAS_LAT, 2, cycles from READ command to first read beat
- BURST_LEN, 4, beats for burst opcodes (≥2)
- CNT_W, 16, timer width; must hold max(INIT_CYCLES, T_XSR, T_RFC)

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- mode  in  1  1 = burst mode, sampled at accept
- opcode  in  3  0 ready, 1 init, 2 self-ref, 3 auto-ref, 4 single rd, 5 burst rd, 6 single wr, 7 burst wr
- idle  out  1  ready to accept an opcode
- done  out  1  one-cycle pulse when a sequence completes
- chip  out  1  data-phase strobe, one cycle per beat
- command  out  4  0 NOP, 1 ACT, 2 RDAP, 3 WRAP, 4 PALL, 5 AREF, 6 SREF, 7 MRS non-burst, 8 MRS burst

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: idle=1, done=0, chip=0, command=0, FSM in IDLE, timer cleared. Reset mid-sequence aborts immediately.
- Accept: on a rising edge with idle=1 and opcode≠0, opcode and mode are latched. Accept cycle is c0; the first command appears in c1 and idle=0 from c1. Opcode/mode changes while busy are ignored, except for self-refresh exit.
- Done: done=1 and idle=1 in the same cycle. A nonzero opcode in that cycle is accepted back-to-back.
- Command outputs: registered. command=0 in every cycle not listed below.
- Beats: 1 for opcodes 4 and 6. BURST_LEN for opcodes 5 and 7 when mode=1. Opcodes 5 and 7 with mode=0 run as single.
- Init:
  - INIT_CYCLES NOPs, then PALL.
  - After PALL, T_RP-1 NOPs.
  - INIT_REFRESHES × (AREF, then T_RFC-1 NOPs).
  - Then MRS: cmd 8 if mode else 7.
  - Then T_MRD-1 NOPs, then done.
- Auto-ref: PALL, T_RP-1 NOPs, AREF, T_RFC-1 NOPs, done.
- Read:
  - ACT, T_RCD-1 NOPs, RDAP.
  - chip=1 for beats cycles starting at RDAP+CAS_LAT.
  - T_RP NOPs after the last beat, then done.
- Write:
  - ACT, T_RCD-1 NOPs, WRAP.
  - chip=1 for beats cycles starting on the WRAP cycle.
  - T_WR+T_RP NOPs after the last beat, then done.
- Self-ref:
  - PALL, T_RP-1 NOPs, SREF, then state SREF_HOLD (NOP, idle=0).
  - Stays in SREF_HOLD while opcode==2. The first edge with opcode≠2 exits.
  - Exit: T_XSR NOPs, then done. The exiting opcode is not accepted.
- States: IDLE, INIT_WAIT, PALL, TRP, AREF, TRFC, MRS, TMRD, ACT, TRCD, RD, WR, DATA, RECOV, SREF, SREF_HOLD, XSR, DONE.
  - Each wait state loads the timer on entry and leaves when the timer reaches zero.
  - An interval of 1 means zero NOPs: the next command follows directly.
- Timer: down-counter, CNT_W bits, no wrap. Loads with an explicit value; never decrements below 0.
- Beat/refresh counters: saturate at their target and are cleared on IDLE entry.

Decomposition:
- Package scg_param_pkg holds:
  - cmd_t enum (values 0–8 above)
  - opcode_t enum (0–7)
  - state_t enum
  - localparam helpers (beats function)
- One sub-module, scg_timer: loadable down-counter with a zero flag, parametrised by CNT_W.

Test Plan:
Common parameters: INIT_CYCLES=10, T_RP=2, T_RCD=2, T_RFC=7, T_MRD=2, T_WR=2, T_XSR=8, CAS_LAT=2, BURST_LEN=4, INIT_REFRESHES=2.
- Init, mode=1, opcode=1 at c0: c1–c10 NOP; c11 PALL; c12 NOP; c13 AREF; c20 AREF; c27 cmd 8; c28 NOP; c29 done=1, idle=1.
- Single read, opcode=4 at c0: c1 ACT; c3 RDAP; chip=1 only at c5; c6–c7 NOP; c8 done.
- Burst write, mode=1, opcode=7: c1 ACT; c3 WRAP; chip=1 c3–c6; c7–c10 NOP; c11 done. Same with mode=0 gives chip at c3 only and done at c8.
- Auto-ref, opcode=3: c1 PALL; c3 AREF; c4–c9 NOP; c10 done. Opcode held at 3 restarts with PALL at c11.
- Self-ref, opcode=2 held: c1 PALL; c3 SREF; idle=0 indefinitely. Opcode→0 at edge c20: c21–c28 NOP; c29 done.
- Reset mid-read (n_rst low at c4 mid-cycle): command=0, chip=0, idle=1 immediately (asynchronous). A new opcode=6 after release runs a clean write.

Source files
------------

// File: rtl/scg_param_pkg.sv
// Shared types for the parametrised SDRAM subroutine command generator:
// command/opcode/state encodings and the beat-count helper.
package scg_param_pkg;

  typedef enum logic [3:0] {
    CMD_NOP       = 4'd0,
    CMD_ACT       = 4'd1,
    CMD_RDAP      = 4'd2,
    CMD_WRAP      = 4'd3,
    CMD_PALL      = 4'd4,
    CMD_AREF      = 4'd5,
    CMD_SREF      = 4'd6,
    CMD_MRS       = 4'd7,
    CMD_MRS_BURST = 4'd8
  } cmd_t;

  typedef enum logic [2:0] {
    OP_READY     = 3'd0,
    OP_INIT      = 3'd1,
    OP_SELF_REF  = 3'd2,
    OP_AUTO_REF  = 3'd3,
    OP_SINGLE_RD = 3'd4,
    OP_BURST_RD  = 3'd5,
    OP_SINGLE_WR = 3'd6,
    OP_BURST_WR  = 3'd7
  } opcode_t;

  typedef enum logic [4:0] {
    S_IDLE, S_INIT_WAIT, S_PALL, S_TRP, S_AREF, S_TRFC, S_MRS, S_TMRD,
    S_ACT, S_TRCD, S_RD, S_WR, S_DATA, S_RECOV, S_SREF, S_SREF_HOLD,
    S_XSR, S_DONE
  } state_t;

  // Burst opcodes only run multi-beat when burst mode was latched.
  function automatic int unsigned beats(opcode_t op, logic mode, int unsigned burst_len);
    if (mode && (op == OP_BURST_RD || op == OP_BURST_WR)) return burst_len;
    return 1;
  endfunction

  function automatic logic is_write(opcode_t op);
    return (op == OP_SINGLE_WR) || (op == OP_BURST_WR);
  endfunction

endpackage

// File: rtl/scg_timer.sv
// Shared interval timer: loadable down-counter that holds at zero.
module scg_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/scg_param.sv
// SDRAM subroutine command generator: one FSM plus a shared interval timer
// expand a controller opcode into its full SDRAM command sequence.
module scg_param
  import scg_param_pkg::*;
#(
  parameter int unsigned INIT_CYCLES    = 14286,
  parameter int unsigned INIT_REFRESHES = 2,
  parameter int unsigned T_RP           = 2,
  parameter int unsigned T_RCD          = 2,
  parameter int unsigned T_RFC          = 7,
  parameter int unsigned T_MRD          = 2,
  parameter int unsigned T_WR           = 2,
  parameter int unsigned T_XSR          = 8,
  parameter int unsigned CAS_LAT        = 2,
  parameter int unsigned BURST_LEN      = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       mode,
  input  logic [2:0] opcode,
  output logic       idle,
  output logic       done,
  output logic       chip,
  output logic [3:0] command
);

  state_t           state, nxt, after_trp, after_trfc;
  opcode_t          op_q;
  logic             mode_q;
  cmd_t             cmd_nxt;
  logic             load, tmr_zero, accept, wr, last_beat;
  logic [CNT_W-1:0] load_val, tmr_cnt, tmr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_tgt, ref_cnt, recov_len;

  scg_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (load),
    .load_val (load_val),
    .count    (tmr_cnt),
    .zero     (tmr_zero)
  );

  assign accept    = (state == S_IDLE || state == S_DONE) && (opcode != 3'd0);
  assign wr        = is_write(op_q);
  assign beat_tgt  = CNT_W'(beats(op_q, mode_q, BURST_LEN));
  assign last_beat = chip && (beat_cnt == beat_tgt - 1'b1);
  assign recov_len = wr ? CNT_W'(T_WR + T_RP) : CNT_W'(T_RP);
  // Timer value seen in the next cycle; lets chip be registered off the timer.
  assign tmr_nxt   = load ? load_val : (tmr_zero ? '0 : tmr_cnt - 1'b1);

  always_comb begin
    after_trp  = S_AREF;
    after_trfc = S_DONE;
    if (op_q == OP_SELF_REF)
      after_trp = S_SREF;
    else if (op_q == OP_INIT && ref_cnt >= CNT_W'(INIT_REFRESHES))
      after_trp = S_MRS;
    if (op_q == OP_INIT)
      after_trfc = (ref_cnt >= CNT_W'(INIT_REFRESHES)) ? S_MRS : S_AREF;
  end

  // Wait states of length n load n-1; a zero-length wait is skipped outright.
  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = '0;
    case (state)
      S_IDLE, S_DONE: begin
        nxt = S_IDLE;
        if (accept) begin
          case (opcode_t'(opcode))
            OP_INIT: begin
              if (INIT_CYCLES > 0) begin
                nxt = S_INIT_WAIT; load = 1'b1; load_val = CNT_W'(INIT_CYCLES - 1);
              end else nxt = S_PALL;
            end
            OP_SELF_REF, OP_AUTO_REF: nxt = S_PALL;
            default:                  nxt = S_ACT;
          endcase
        end
      end
      S_INIT_WAIT: if (tmr_zero) nxt = S_PALL;
      S_PALL: begin
        if (T_RP > 1) begin
          nxt = S_TRP; load = 1'b1; load_val = CNT_W'(T_RP - 2);
        end else nxt = after_trp;
      end
      S_TRP: if (tmr_zero) nxt = after_trp;
      S_AREF: begin
        if (T_RFC > 1) begin
          nxt = S_TRFC; load = 1'b1; load_val = CNT_W'(T_RFC - 2);
        end else nxt = after_trfc;
      end
      S_TRFC: if (tmr_zero) nxt = after_trfc;
      S_MRS: begin
        if (T_MRD > 1) begin
          nxt = S_TMRD; load = 1'b1; load_val = CNT_W'(T_MRD - 2);
        end else nxt = S_DONE;
      end
      S_TMRD: if (tmr_zero) nxt = S_DONE;
      S_ACT: begin
        if (T_RCD > 1) begin
          nxt = S_TRCD; load = 1'b1; load_val = CNT_W'(T_RCD - 2);
        end else nxt = wr ? S_WR : S_RD;
      end
      S_TRCD: if (tmr_zero) nxt = wr ? S_WR : S_RD;
      S_RD: begin
        nxt = S_DATA; load = 1'b1; load_val = CNT_W'(CAS_LAT - 1);
      end
      S_WR, S_DATA: begin
        if (last_beat) begin
          if (recov_len != '0) begin
            nxt = S_RECOV; load = 1'b1; load_val = recov_len - 1'b1;
          end else nxt = S_DONE;
        end else if (state == S_WR) begin
          nxt = S_DATA; load = 1'b1;
        end
      end
      S_RECOV: if (tmr_zero) nxt = S_DONE;
      S_SREF:  nxt = S_SREF_HOLD;
      S_SREF_HOLD: begin
        if (opcode_t'(opcode) != OP_SELF_REF) begin
          if (T_XSR > 0) begin
            nxt = S_XSR; load = 1'b1; load_val = CNT_W'(T_XSR - 1);
          end else nxt = S_DONE;
        end
      end
      S_XSR:   if (tmr_zero) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (nxt)
      S_PALL:  cmd_nxt = CMD_PALL;
      S_AREF:  cmd_nxt = CMD_AREF;
      S_MRS:   cmd_nxt = mode_q ? CMD_MRS_BURST : CMD_MRS;
      S_ACT:   cmd_nxt = CMD_ACT;
      S_RD:    cmd_nxt = CMD_RDAP;
      S_WR:    cmd_nxt = CMD_WRAP;
      S_SREF:  cmd_nxt = CMD_SREF;
      default: cmd_nxt = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      op_q     <= OP_READY;
      mode_q   <= 1'b0;
      command  <= CMD_NOP;
      chip     <= 1'b0;
      done     <= 1'b0;
      idle     <= 1'b1;
      beat_cnt <= '0;
      ref_cnt  <= '0;
    end else begin
      state   <= nxt;
      command <= cmd_nxt;
      chip    <= (nxt == S_WR) || (nxt == S_DATA && tmr_nxt == '0);
      done    <= (nxt == S_DONE);
      idle    <= (nxt == S_IDLE) || (nxt == S_DONE);
      if (accept) begin
        op_q   <= opcode_t'(opcode);
        mode_q <= mode;
      end
      if (nxt == S_IDLE || nxt == S_DONE) begin
        beat_cnt <= '0;
        ref_cnt  <= '0;
      end else begin
        if (chip && beat_cnt != beat_tgt)
          beat_cnt <= beat_cnt + 1'b1;
        if (nxt == S_AREF && ref_cnt != CNT_W'(INIT_REFRESHES))
          ref_cnt <= ref_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scg_param.sv
// Bench for scg_param: per-opcode expected command/chip traces are built from
// the timing rules and compared cycle by cycle, with random busy-time inputs.
module tb_scg_param;

  localparam int INIT_CYCLES    = 10;
  localparam int INIT_REFRESHES = 2;
  localparam int T_RP           = 2;
  localparam int T_RCD          = 2;
  localparam int T_RFC          = 7;
  localparam int T_MRD          = 2;
  localparam int T_WR           = 2;
  localparam int T_XSR          = 8;
  localparam int CAS_LAT        = 2;
  localparam int BURST_LEN      = 4;
  localparam int RND            = 8;  // drive marker: random opcode/mode

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] opcode = '0;
  logic       idle, done, chip;
  logic [3:0] command;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_op = 0;

  int q_cmd[$];
  bit q_chip[$];
  int q_drv[$];

  scg_param #(
    .INIT_CYCLES(INIT_CYCLES), .INIT_REFRESHES(INIT_REFRESHES), .T_RP(T_RP),
    .T_RCD(T_RCD), .T_RFC(T_RFC), .T_MRD(T_MRD), .T_WR(T_WR), .T_XSR(T_XSR),
    .CAS_LAT(CAS_LAT), .BURST_LEN(BURST_LEN), .CNT_W(16)
  ) dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .opcode(opcode),
    .idle(idle), .done(done), .chip(chip), .command(command)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int c, input int ch, input int dn, input int idl);
    chk({tag, ".cmd"},  8'(command), 8'(c));
    chk({tag, ".chip"}, 8'(chip),    8'(ch));
    chk({tag, ".done"}, 8'(done),    8'(dn));
    chk({tag, ".idle"}, 8'(idle),    8'(idl));
  endtask

  task automatic push(input int c, input bit ch, input int drv, input int n);
    for (int k = 0; k < n; k++) begin
      q_cmd.push_back(c);
      q_chip.push_back(ch);
      q_drv.push_back(drv);
    end
  endtask

  // Expected trace for cycles c1..done; the last entry is the done cycle.
  task automatic build(input int op, input bit m, input int hold, input int exitv);
    int b;
    q_cmd.delete(); q_chip.delete(); q_drv.delete();
    b = ((op == 5 || op == 7) && m) ? BURST_LEN : 1;
    case (op)
      1: begin
        push(0, 0, RND, INIT_CYCLES);
        push(4, 0, RND, 1);
        push(0, 0, RND, T_RP - 1);
        for (int r = 0; r < INIT_REFRESHES; r++) begin
          push(5, 0, RND, 1);
          push(0, 0, RND, T_RFC - 1);
        end
        push(m ? 8 : 7, 0, RND, 1);
        push(0, 0, RND, T_MRD - 1);
      end
      2: begin
        push(4, 0, RND, 1);
        push(0, 0, RND, T_RP - 1);
        push(6, 0, RND, 1);
        push(0, 0, 2, hold - 1);
        push(0, 0, exitv, 1);
        push(0, 0, RND, T_XSR);
      end
      3: begin
        push(4, 0, RND, 1);
        push(0, 0, RND, T_RP - 1);
        push(5, 0, RND, 1);
        push(0, 0, RND, T_RFC - 1);
      end
      4, 5: begin
        push(1, 0, RND, 1);
        push(0, 0, RND, T_RCD - 1);
        push(2, 0, RND, 1);
        push(0, 0, RND, CAS_LAT - 1);
        push(0, 1, RND, b);
        push(0, 0, RND, T_RP);
      end
      default: begin
        push(1, 0, RND, 1);
        push(0, 0, RND, T_RCD - 1);
        push(3, 1, RND, 1);
        push(0, 1, RND, b - 1);
        push(0, 0, RND, T_WR + T_RP);
      end
    endcase
    push(0, 0, 0, 1);
  endtask

  // Step through the first n expected cycles: check, then drive this cycle's inputs.
  task automatic run(input int n);
    int last;
    last = q_cmd.size() - 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_out($sformatf("op%0d.c%0d", cur_op, i + 1), q_cmd[i], int'(q_chip[i]),
              (i == last) ? 1 : 0, (i == last) ? 1 : 0);
      if (q_drv[i] == RND) begin
        opcode = 3'($urandom_range(0, 7));
        mode   = 1'($urandom_range(0, 1));
      end else begin
        opcode = 3'(q_drv[i]);
      end
    end
  endtask

  task automatic seq(input int op, input bit m, input int hold, input int exitv);
    cur_op = op;
    build(op, m, hold, exitv);
    opcode = 3'(op);
    mode   = m;
    run(q_cmd.size());
  endtask

  task automatic gap(input int n);
    opcode = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_out($sformatf("gap%0d", i), 0, 0, 0, 1);
    end
  endtask

  task automatic reset_mid(input int op, input bit m, input int at);
    cur_op = op;
    build(op, m, 1, 0);
    opcode = 3'(op);
    mode   = m;
    run(at);
    #2 n_rst = 1'b0;
    opcode = '0;
    #1 chk_out($sformatf("async_rst_op%0d", op), 0, 0, 0, 1);
    @(negedge clk);
    chk_out("held_rst", 0, 0, 0, 1);
    n_rst = 1'b1;
  endtask

  initial begin
    int op, hold, exitv;
    bit m;
    repeat (2) @(negedge clk);
    chk_out("in_reset", 0, 0, 0, 1);
    n_rst = 1'b1;
    @(negedge clk);
    chk_out("post_reset", 0, 0, 0, 1);

    seq(1, 1, 1, 0);  gap(1);
    seq(4, 0, 1, 0);  gap(2);
    seq(7, 1, 1, 0);  gap(1);
    seq(7, 0, 1, 0);  gap(1);
    seq(5, 1, 1, 0);  gap(1);
    seq(3, 0, 1, 0);
    seq(3, 0, 1, 0);  gap(1);
    seq(2, 0, 17, 0); gap(1);
    reset_mid(4, 0, 4);
    seq(6, 0, 1, 0);  gap(1);
    reset_mid(5, 1, 5);
    seq(7, 1, 1, 0);  gap(1);
    seq(1, 0, 1, 0);

    for (int it = 0; it < 40; it++) begin
      op    = int'($urandom_range(1, 7));
      m     = 1'($urandom_range(0, 1));
      hold  = int'($urandom_range(1, 6));
      exitv = (2 + int'($urandom_range(1, 7))) % 8;
      seq(op, m, hold, exitv);
      if ($urandom_range(0, 1) == 1) gap(int'($urandom_range(1, 3)));
    end
    gap(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
